// File: rtl/wf_gather_ram_mp_if.sv
// -----------------------------------------------------------------------------
// wf_gather_ram_mp_if
//
// Bundle of every non-clock signal of the wavefront gather buffer.
//   master : gather writers / operand-collector consumers (drive writes,
//            invalidates, read requests and response-ready).
//   slave  : the gather buffer itself (drives request-ready, responses,
//            occupancy).
//
// Signal summary
//   wr_en / wr_addr / wr_mask / wr_data : lane-masked write port
//   inv_en / inv_addr / inv_all         : valid-bit invalidation
//   rd_req_valid / rd_req_ready / rd_req_addr             : NUM_RD request channels
//   rd_rsp_valid / rd_rsp_ready / rd_rsp_data / rd_rsp_hit : NUM_RD response channels
//   occupancy                           : registered count of valid entries
// -----------------------------------------------------------------------------
interface wf_gather_ram_mp_if #(
  parameter int  DATA_W = 38,
  parameter int  DEPTH  = 16,
  parameter int  LANES  = 2,
  parameter int  NUM_RD = 2,
  localparam int ADDR_W = $clog2(DEPTH)
);

  logic                       wr_en;
  logic [ADDR_W-1:0]          wr_addr;
  logic [LANES-1:0]           wr_mask;
  logic [DATA_W-1:0]          wr_data;

  logic                       inv_en;
  logic [ADDR_W-1:0]          inv_addr;
  logic                       inv_all;

  logic [NUM_RD-1:0]          rd_req_valid;
  logic [NUM_RD-1:0]          rd_req_ready;
  logic [NUM_RD*ADDR_W-1:0]   rd_req_addr;

  logic [NUM_RD-1:0]          rd_rsp_valid;
  logic [NUM_RD-1:0]          rd_rsp_ready;
  logic [NUM_RD*DATA_W-1:0]   rd_rsp_data;
  logic [NUM_RD-1:0]          rd_rsp_hit;

  logic [ADDR_W:0]            occupancy;

  modport master (
    output wr_en, wr_addr, wr_mask, wr_data,
    output inv_en, inv_addr, inv_all,
    output rd_req_valid, rd_req_addr, rd_rsp_ready,
    input  rd_req_ready, rd_rsp_valid, rd_rsp_data, rd_rsp_hit,
    input  occupancy
  );

  modport slave (
    input  wr_en, wr_addr, wr_mask, wr_data,
    input  inv_en, inv_addr, inv_all,
    input  rd_req_valid, rd_req_addr, rd_rsp_ready,
    output rd_req_ready, rd_rsp_valid, rd_rsp_data, rd_rsp_hit,
    output occupancy
  );

endinterface

// File: rtl/wf_gather_ram_mp.sv
// -----------------------------------------------------------------------------
// wf_gather_ram_mp
//
// Multi-read-port gather buffer for per-wavefront operand collection.
// DEPTH x DATA_W storage with per-lane write masks, a per-entry valid bitmap
// with single/all invalidate, NUM_RD independent read ports (1-cycle latency,
// ready/valid response holding) and a registered occupancy count.
//
// Ports
//   clock    : sole clock, rising edge
//   reset_n  : asynchronous active-low reset
//   bus      : wf_gather_ram_mp_if.slave (write, invalidate, read, occupancy)
//
// Behaviour notes
//   - Reads are write-first: a same-cycle write to the requested entry is
//     merged lane by lane into the response.
//   - Hit is taken from the bitmap after this cycle's write/invalidate.
//   - A miss returns all-zero data.
//   - A write that sets an entry's valid bit wins over inv_en/inv_all.
// -----------------------------------------------------------------------------
module wf_gather_ram_mp #(
  parameter int  DATA_W = 38,
  parameter int  DEPTH  = 16,
  parameter int  LANES  = 2,
  parameter int  NUM_RD = 2,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic                    clock,
  input  logic                    reset_n,
  wf_gather_ram_mp_if.slave       bus
);

  localparam int LANE_W = DATA_W / LANES;

  // Storage and bookkeeping
  logic [DATA_W-1:0]        mem_q [DEPTH];
  logic [DEPTH-1:0]         valid_q, valid_d;
  logic [ADDR_W:0]          occ_q, occ_d;

  // Write path
  logic                     wr_fire;
  logic [DATA_W-1:0]        wr_merged;

  // Read path
  logic [NUM_RD-1:0]        req_ready;
  logic [NUM_RD-1:0]        accept;
  logic [NUM_RD-1:0]        hit_d;
  logic [NUM_RD*DATA_W-1:0] data_d;

  logic [NUM_RD-1:0]        rsp_valid_q;
  logic [NUM_RD-1:0]        rsp_hit_q;
  logic [NUM_RD*DATA_W-1:0] rsp_data_q;

  // ---------------------------------------------------------------------------
  // Write merge: unmasked lanes keep the stored contents. An all-zero mask is
  // a no-op, including for the valid bit.
  // ---------------------------------------------------------------------------
  // NOTE: combinational blocks use blocking '=' so later statements see the
  // updated value; clocked blocks use '<=' so all registers update together.
  always_comb begin
    wr_fire   = bus.wr_en & (|bus.wr_mask);
    wr_merged = mem_q[bus.wr_addr];
    for (int k = 0; k < LANES; k++) begin
      if (bus.wr_mask[k]) begin
        wr_merged[k*LANE_W +: LANE_W] = bus.wr_data[k*LANE_W +: LANE_W];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Valid bitmap update. Statement order encodes priority: invalidates first,
  // then the write sets its entry, so a same-cycle write survives inv_all.
  // ---------------------------------------------------------------------------
  // NOTE: every variable gets a default at the top of the block; without it a
  // path that skips an assignment would infer a latch.
  always_comb begin
    valid_d = valid_q;
    if (bus.inv_all) valid_d = '0;
    if (bus.inv_en)  valid_d[bus.inv_addr] = 1'b0;
    if (wr_fire)     valid_d[bus.wr_addr]  = 1'b1;
  end

  // Popcount of the post-update bitmap; needs ADDR_W+1 bits to reach DEPTH.
  always_comb begin
    occ_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occ_d = occ_d + (ADDR_W+1)'(valid_d[i]);
    end
  end

  // ---------------------------------------------------------------------------
  // Read ports. A port can take a new request whenever its response register
  // is empty or being drained this cycle, giving one read per cycle per port.
  // ---------------------------------------------------------------------------
  always_comb begin
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] word;
    a         = '0;
    word      = '0;
    req_ready = ~rsp_valid_q | bus.rd_rsp_ready;
    accept    = bus.rd_req_valid & req_ready;
    hit_d     = '0;
    data_d    = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      a    = bus.rd_req_addr[p*ADDR_W +: ADDR_W];
      // Write-first bypass: the merged word is exactly what the array will
      // hold after this edge.
      word = (wr_fire && (bus.wr_addr == a)) ? wr_merged : mem_q[a];
      hit_d[p] = valid_d[a];
      data_d[p*DATA_W +: DATA_W] = valid_d[a] ? word : '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Storage array
  // ---------------------------------------------------------------------------
  // NOTE: the array is deliberately left out of reset so it maps onto RAM;
  // the valid bitmap alone decides whether its contents are meaningful.
  always_ff @(posedge clock) begin
    if (wr_fire) begin
      mem_q[bus.wr_addr] <= wr_merged;
    end
  end

  // ---------------------------------------------------------------------------
  // Bitmap, occupancy and response registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_q     <= '0;
      occ_q       <= '0;
      rsp_valid_q <= '0;
      rsp_hit_q   <= '0;
      rsp_data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      occ_q   <= occ_d;
      for (int p = 0; p < NUM_RD; p++) begin
        if (accept[p]) begin
          rsp_valid_q[p]                 <= 1'b1;
          rsp_hit_q[p]                   <= hit_d[p];
          rsp_data_q[p*DATA_W +: DATA_W] <= data_d[p*DATA_W +: DATA_W];
        end else if (bus.rd_rsp_ready[p]) begin
          // Drained with nothing behind it: clear so idle data reads as zero.
          rsp_valid_q[p]                 <= 1'b0;
          rsp_hit_q[p]                   <= 1'b0;
          rsp_data_q[p*DATA_W +: DATA_W] <= '0;
        end
        // Otherwise stalled: hold data and hit regardless of later writes.
      end
    end
  end

  assign bus.rd_req_ready = req_ready;
  assign bus.rd_rsp_valid = rsp_valid_q;
  assign bus.rd_rsp_hit   = rsp_hit_q;
  assign bus.rd_rsp_data  = rsp_data_q;
  assign bus.occupancy    = occ_q;

endmodule

// File: doc/wf_gather_ram_mp.md
# wf_gather_ram_mp

Parametrised multi-read-port gather buffer for per-wavefront operand collection. It is a single-clock successor to the fixed 16x38 gather RAM and adds per-lane write masks, NUM_RD independent read ports with ready/valid response holding, per-entry valid tracking with invalidate, and an occupancy count. It sits between the warp scheduler's gather writers and the operand-collector consumers inside each SM.

## Interface
- DATA_W, 38, entry width in bits; must be divisible by LANES.
- DEPTH, 16, number of entries; power of two, at least 2.
- ADDR_W, $clog2(DEPTH), address width; derived, not overridden.
- LANES, 2, number of write-mask lanes; lane k covers bits [k*DATA_W/LANES +: DATA_W/LANES].
- NUM_RD, 2, number of read ports.

Ports:
- clock  in  1  sole clock; all state is rising-edge.
- reset_n  in  1  asynchronous, active-low reset.
- wr_en  in  1  write strobe.
- wr_addr  in  ADDR_W  write entry.
- wr_mask  in  LANES  per-lane write enable.
- wr_data  in  DATA_W  write data.
- inv_en  in  1  clear the valid bit of inv_addr.
- inv_addr  in  ADDR_W  entry to invalidate.
- inv_all  in  1  clear all valid bits.
- rd_req_valid  in  NUM_RD  per-port read request.
- rd_req_ready  out  NUM_RD  per-port request accept.
- rd_req_addr  in  NUM_RD*ADDR_W  per-port address; port p uses slice [p*ADDR_W +: ADDR_W].
- rd_rsp_valid  out  NUM_RD  per-port response valid.
- rd_rsp_ready  in  NUM_RD  per-port response accept.
- rd_rsp_data  out  NUM_RD*DATA_W  per-port response data.
- rd_rsp_hit  out  NUM_RD  the read entry was valid.
- occupancy  out  ADDR_W+1  number of valid entries.

## Operation
- Storage: DEPTH x DATA_W array with no reset, plus a DEPTH-bit valid bitmap.
- Write: when wr_en is high, each lane with wr_mask[k]=1 is updated, and the other lanes keep their contents. The valid bit is set if any mask bit is set. wr_en with wr_mask=0 is a complete no-op.
- Invalidate: inv_en clears valid[inv_addr]. inv_all clears every bit.
- Same-cycle priority: a write that sets an entry's valid bit overrides both inv_en and inv_all for that entry. inv_all clears every other entry.
- Read accept: port p accepts when rd_req_valid[p] & rd_req_ready[p]. rd_req_ready[p] = !rd_rsp_valid[p] | rd_rsp_ready[p], which is combinational and gives full throughput.
- Read data is write-first. If the same cycle writes the requested address, the response merges the new lanes with the old lanes.
- Read hit is post-update: the hit reflects the bitmap after that cycle's write and invalidate.
- When hit=0, the response data is all zeros; it is never stale or random.
- Ports are independent. Any number of ports may read the same address in the same cycle.
- Hold: while rd_rsp_valid[p] & !rd_rsp_ready[p], data and hit are frozen, even if the entry is later written or invalidated.
- The response register is cleared when rd_rsp_ready[p] is high and no new request is accepted.
- occupancy is a registered popcount of the bitmap after update.

## Timing
- Reset (asynchronous assert, synchronous-safe deassert) clears:
  - the valid bitmap;
  - rd_rsp_valid, rd_rsp_data and rd_rsp_hit to 0;
  - occupancy to 0.
- Reset does not touch the memory array.
- While reset_n is low, rd_req_ready = all ones, because it is derived from rd_rsp_valid=0.
- Read latency is 1 cycle: a request accepted at edge N gives rd_rsp_valid=1 after edge N.
- Back-to-back reads on every cycle are sustained when rd_rsp_ready=1.
- Write-to-read: a write at edge N is visible to a read accepted at edge N, through the bypass.
- occupancy reflects the updates of edge N immediately after edge N.
- Reset asserted mid-operation drops all pending responses with no handshake. A response held under stall is lost.
- Bounds: occupancy reaches DEPTH when all entries are valid (ADDR_W+1 bits are needed). Addresses wrap naturally within ADDR_W.

## Test plan
- Reset/basic: after reset, occupancy=0. Write addr 3 with 0x2A_AAAA_AAAA and mask 2'b11, then read port 0 addr 3 in the next cycle. Required: one cycle later rsp_valid=1, hit=1, data=0x2A_AAAA_AAAA, occupancy=1.
- Masked write and bypass: entry 5 holds 0x3F_FFFF_FFFF. In one cycle, write addr 5 with data 0 and mask 2'b01, and read addr 5 on port 1. Required: data=0x3F_FFF8_0000 (upper 19 bits kept, lower 19 bits zero) and hit=1.
- Invalidate and priority:
  - Invalidate addr 5, then read it. Required: hit=0, data=0, occupancy decremented.
  - In one cycle, apply inv_all together with a write to addr 7. Required: occupancy=1 and a read of addr 7 hits.
- Stall hold: read addr 2 on port 0 with rd_rsp_ready=0 for 4 cycles while addr 2 is overwritten. Required: rsp_data keeps the old value and rd_req_ready[0]=0 throughout. When ready=1, the response is consumed in the same cycle as a new accept.
- Parallel ports: on every cycle, port 0 and port 1 read the same and then different addresses, with random ready. Required: each port's responses match a scoreboard in order, with no drops or duplicates.
- Full/reset mid-flight: fill all 16 entries. Required: occupancy=16. Then assert reset_n low while rsp_valid=1 with stall. Required: all rsp_valid=0 and occupancy=0 immediately, and no response after deassert.
